// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: default widths, reset and
// handler vectors, and the default-width stage entry layout.
package pipe_pkg;

  localparam int INSTR_W_DEF = 32;
  localparam int PC_W_DEF    = 32;
  localparam int EXC_W_DEF   = 5;

  localparam int          EXC_NONE   = 0;
  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [PC_W_DEF-1:0]    pc;
    logic [PC_W_DEF-1:0]    pc8;
    logic [EXC_W_DEF-1:0]   exc;
    logic                   bd;
  } pipe_entry_t;

endpackage

// File: rtl/pipe_entry_load.sv
// Forms the entry written into M or S: bubble masking on clr plus the pc+8 add.
module pipe_entry_load
  import pipe_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int EXC_W   = 5
) (
  input  logic               clr,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [EXC_W-1:0]   in_exc,
  input  logic               in_bd,
  output logic [INSTR_W-1:0] ld_instr,
  output logic [PC_W-1:0]    ld_pc,
  output logic [PC_W-1:0]    ld_pc8,
  output logic [EXC_W-1:0]   ld_exc,
  output logic               ld_bd
);

  // A bubble keeps pc and bd so the exception PC of the slot stays correct.
  assign ld_instr = clr ? '0 : in_instr;
  assign ld_exc   = clr ? EXC_W'(EXC_NONE) : in_exc;
  assign ld_pc    = in_pc;
  assign ld_pc8   = in_pc + PC_W'(8);
  assign ld_bd    = in_bd;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with bubble insertion, interrupt flush and
// an optional skid entry that registers in_ready.
module pipe_stage_reg #(
  parameter int              INSTR_W    = 32,
  parameter int              PC_W       = 32,
  parameter int              EXC_W      = 5,
  parameter logic [PC_W-1:0] RESET_PC   = PC_W'(pipe_pkg::RESET_PC),
  parameter logic [PC_W-1:0] HANDLER_PC = PC_W'(pipe_pkg::HANDLER_PC),
  parameter bit              SKID       = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [EXC_W-1:0]   in_exc,
  input  logic               in_bd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [PC_W-1:0]    out_pc8,
  output logic [EXC_W-1:0]   out_exc,
  output logic               out_bd
);

  // Handshake: a transfer happens on a clock edge where valid and ready are both
  // high on the same side; neither side may make valid depend on ready.
  logic               m_valid, s_valid;
  logic [INSTR_W-1:0] m_instr, s_instr, ld_instr;
  logic [PC_W-1:0]    m_pc, s_pc, ld_pc;
  logic [PC_W-1:0]    m_pc8, s_pc8, ld_pc8;
  logic [EXC_W-1:0]   m_exc, s_exc, ld_exc;
  logic               m_bd, s_bd, ld_bd;
  logic               accept, drain;

  pipe_entry_load #(
    .INSTR_W (INSTR_W),
    .PC_W    (PC_W),
    .EXC_W   (EXC_W)
  ) u_load (
    .clr      (clr),
    .in_instr (in_instr),
    .in_pc    (in_pc),
    .in_exc   (in_exc),
    .in_bd    (in_bd),
    .ld_instr (ld_instr),
    .ld_pc    (ld_pc),
    .ld_pc8   (ld_pc8),
    .ld_exc   (ld_exc),
    .ld_bd    (ld_bd)
  );

  // With the skid entry, ready depends only on state, breaking the stall path.
  assign in_ready = SKID ? ~s_valid : (~m_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign drain    = m_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset || req) begin
      m_valid <= 1'b0;
      m_instr <= '0;
      m_pc    <= reset ? RESET_PC : HANDLER_PC;
      m_pc8   <= '0;
      m_exc   <= '0;
      m_bd    <= 1'b0;
      s_valid <= 1'b0;
      s_instr <= '0;
      s_pc    <= '0;
      s_pc8   <= '0;
      s_exc   <= '0;
      s_bd    <= 1'b0;
    end else if (SKID && drain && s_valid) begin
      m_instr <= s_instr;
      m_pc    <= s_pc;
      m_pc8   <= s_pc8;
      m_exc   <= s_exc;
      m_bd    <= s_bd;
      s_valid <= 1'b0;
      s_instr <= '0;
      s_pc    <= '0;
      s_pc8   <= '0;
      s_exc   <= '0;
      s_bd    <= 1'b0;
    end else if (accept) begin
      if (!SKID || !m_valid || drain) begin
        m_valid <= 1'b1;
        m_instr <= ld_instr;
        m_pc    <= ld_pc;
        m_pc8   <= ld_pc8;
        m_exc   <= ld_exc;
        m_bd    <= ld_bd;
      end else begin
        s_valid <= 1'b1;
        s_instr <= ld_instr;
        s_pc    <= ld_pc;
        s_pc8   <= ld_pc8;
        s_exc   <= ld_exc;
        s_bd    <= ld_bd;
      end
    end else if (drain) begin
      m_valid <= 1'b0;
    end
  end

  assign out_valid = m_valid;
  assign out_instr = m_instr;
  assign out_pc    = m_pc;
  assign out_pc8   = m_pc8;
  assign out_exc   = m_exc;
  assign out_bd    = m_bd;

endmodule
